// File: rtl/axis_tx_mmio.sv
// Memory-mapped AXI-Stream transmit port: CPU pushes words into a small
// FIFO through the peripheral window, the FIFO head drives the stream master.
module axis_tx_mmio #(
  parameter int          AXIS_DATA_WIDTH = 8,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [31:0] SOC_SEGMENT     = 32'he4,
  parameter logic [31:0] SOC_CLASS       = 32'ha9
) (
  input  logic                       axis_aclk_i,
  input  logic                       axis_areset_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                data_i,
  input  logic                       data_w_i,
  output logic [31:0]                data_o,
  output logic                       data_access_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                       m_axis_tlast_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = AXIS_DATA_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [LW-1:0] level;
  logic          overflow;

  logic        wr;
  logic        rd;
  logic        sel_stat;
  logic        sel_data;
  logic        sel_last;
  logic        sel_ctrl;
  logic        push;
  logic        pop;
  logic        accept;
  logic        drop;
  logic        clr;
  logic [31:0] status;
  logic [31:0] rdata;
  logic        unused_bits;

  assign data_access_o = (addr_i[31:24] == SOC_SEGMENT[7:0]) &&
                         (addr_i[23:16] == SOC_CLASS[7:0]);

  assign sel_stat = addr_i[6:4] == 3'd1;
  assign sel_data = addr_i[6:4] == 3'd2;
  assign sel_last = addr_i[6:4] == 3'd3;
  assign sel_ctrl = addr_i[6:4] == 3'd4;

  assign wr = data_access_o && data_w_i;
  assign rd = data_access_o && !data_w_i;

  assign m_axis_tvalid_o = level != '0;
  assign {m_axis_tlast_o, m_axis_tdata_o} = mem[rptr];

  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign pop    = m_axis_tvalid_o && m_axis_tready_i;
  assign push   = wr && (sel_data || sel_last);
  assign accept = push && ((level != DEPTH) || pop);
  assign drop   = push && !accept;
  assign clr    = wr && sel_ctrl && data_i[0];

  assign unused_bits = ^{addr_i[15:7], addr_i[3:0],
                         data_i[31:AXIS_DATA_WIDTH]};

  always_comb begin
    status         = '0;
    status[0]      = level == '0;
    status[1]      = level == DEPTH;
    status[2]      = overflow;
    status[3]      = m_axis_tvalid_o;
    status[8 +: LW] = level;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_stat: rdata = status;
      sel_ctrl: rdata = {31'b0, overflow};
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wptr] <= {sel_last, data_i[AXIS_DATA_WIDTH-1:0]};
    end
  end

  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      rptr     <= '0;
      wptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      data_o   <= '0;
    end else begin
      if (accept) wptr <= wptr + PW'(1);
      if (pop)    rptr <= rptr + PW'(1);
      level <= level + LW'(accept) - LW'(pop);
      if (drop)
        overflow <= 1'b1;
      else if (clr)
        overflow <= 1'b0;
      if (rd) data_o <= rdata;
    end
  end

endmodule

// File: doc/axis_tx_mmio.md
# axis_tx_mmio

Memory-mapped AXI-Stream master (transmit) port for the SoC peripheral bus. The CPU writes bytes into a small FIFO through the peripheral address window, and the block presents them on an AXI-Stream master interface using standard TVALID/TREADY handshaking, with optional TLAST per word. Status (empty, full, level, sticky overflow) is readable through the same window. It is the transmit counterpart of the existing AXI-Stream receive peripheral and shares its address decode and bus-side timing.

## Interface
- AXIS_DATA_WIDTH, 8: stream data width in bits, 1..24.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of two, 2..16.
- SOC_SEGMENT, 32'he4: matched against addr_i[31:24].
- SOC_CLASS, 32'ha9: matched against addr_i[23:16].
- axis_aclk_i  in  1  the single clock; all state is on its rising edge.
- axis_areset_i  in  1  reset, asynchronous and active-high.
- addr_i  in  32  CPU address.
- data_i  in  32  CPU write data.
- data_w_i  in  1  write strobe, qualified by data_access_o.
- data_o  out  32  registered read data.
- data_access_o  out  1  combinational address-window hit.
- m_axis_tvalid_o  out  1  stream data valid.
- m_axis_tready_i  in  1  sink ready.
- m_axis_tdata_o  out  AXIS_DATA_WIDTH  stream data (FIFO head).
- m_axis_tlast_o  out  1  end-of-packet flag of the head entry.

## Operation
- The decode is data_access_o = (addr_i[31:24]==SOC_SEGMENT) && (addr_i[23:16]==SOC_CLASS). The register is selected by addr_i[6:4]. Base address with the defaults is 0xe4a90000.
- Offset 0x10 STATUS (RO):
  - bit0 = empty
  - bit1 = full
  - bit2 = overflow (sticky)
  - bit3 = m_axis_tvalid_o
  - bits[12:8] = level (0..FIFO_DEPTH)
  - other bits 0.
- Offset 0x20 TXDATA (WO): a write pushes {tlast=0, data_i[AXIS_DATA_WIDTH-1:0]}.
- Offset 0x30 TXLAST (WO): a write pushes {tlast=1, data_i[AXIS_DATA_WIDTH-1:0]}.
- Offset 0x40 CTRL (W): writing data_i[0]=1 clears overflow. A read returns {31'b0, overflow}.
- Reads:
  - Any access with data_w_i=0 loads data_o at the next edge.
  - Write-only and unmapped offsets load 0.
  - With no access, data_o holds its value.
  - Writes never change data_o.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth.
  - A level counter of log2(FIFO_DEPTH)+1 bits.
  - Storage is reset to 0.
- Stream output:
  - m_axis_tvalid_o = (level != 0).
  - tdata/tlast = entry at the read pointer.
  - Pop on any edge where tvalid && tready.
- AXI-Stream rules:
  - Once tvalid rises it stays high, with tdata/tlast stable, until the handshake edge.
  - No path exists to drop a presented entry.
- Push acceptance:
  - Accepted if level < FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the word is dropped and overflow is set.
  - The level is unchanged on a simultaneous push and pop.
- Simultaneous overflow clear and a dropped push on one edge cannot occur, since they are different offsets. Set has priority if ever both are true.

## Timing
- Reset (asynchronous, immediate): data_o=0, m_axis_tvalid_o=0, m_axis_tdata_o=0, m_axis_tlast_o=0, level=0, pointers=0, overflow=0. Reset mid-transfer discards all FIFO contents.
- data_access_o is combinational, with zero latency.
- Read latency is one cycle: data_o reflects state sampled before the access edge. A STATUS read on the same edge as a push shows the pre-push level.
- Push-to-tvalid latency is one cycle: a write at edge N into an empty FIFO gives tvalid=1 after edge N.
- Throughput is one beat per cycle with tready held high and the CPU writing every cycle.
- Push into an empty FIFO with tready=1: the handshake occurs at edge N+1, and tvalid falls after it if nothing else is pushed.

## Test plan
- Reset values:
  - Assert axis_areset_i mid-run with 3 entries queued.
  - Required: all outputs 0 immediately, and a STATUS read returns 0x00000001.
- Single beat:
  - tready=1, write 0x1A5 to 0xe4a90020.
  - Required: tvalid=1 for exactly one cycle after the write edge, tdata=0xA5, tlast=0.
  - A STATUS read afterwards returns 0x00000001.
- Backpressure and overflow:
  - tready=0, write 0x11,0x22,0x33,0x44,0x55 to TXDATA.
  - Required: STATUS=0x0000040E after the writes.
  - With tready=1, drain 0x11,0x22,0x33,0x44 in order. 0x55 is never output.
- Stability under stall:
  - With tready toggling pseudo-randomly, check every cycle that tdata/tlast do not change while tvalid=1 and tready=0.
- Full with simultaneous push/pop:
  - FIFO full (0x11..0x44), tready=1, write 0x99 on the same edge as the pop of 0x11.
  - Required: push accepted, overflow stays 0, level stays 4, later output order 0x22,0x33,0x44,0x99.
- TLAST and CTRL:
  - Write 0x01 to TXDATA, then 0x02 to TXLAST.
  - Required: tlast=0 then 1 on the respective beats.
  - After a forced overflow, write 1 to 0xe4a90040; a read of 0x40 returns 0.
  - A read of 0xe4a80010 gives data_access_o=0 and data_o unchanged.
